// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg                                                                    |
// | GF(2^8) helpers, MixColumns coefficient rows and the engine state type.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam logic [7:0]  AES_POLY = 8'h1B;
  // First row of each circulant matrix, one nibble per coefficient, index 0 first
  localparam logic [15:0] MC_FWD   = {4'h2, 4'h3, 4'h1, 4'h1};
  localparam logic [15:0] MC_INV   = {4'he, 4'hb, 4'hd, 4'h9};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (coef[0] ? b  : 8'h00) ^ (coef[1] ? x2 : 8'h00) ^
           (coef[2] ? x4 : 8'h00) ^ (coef[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [3:0] mc_coef(input logic inv, input int idx);
    logic [15:0] row;
    row = inv ? MC_INV : MC_FWD;
    return row[15-4*idx -: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column_word.sv
// +----------------------------------------------------------------------------+
// | mix_column_word                                                            |
// | Combinational MixColumns / InvMixColumns of one 32-bit column.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  // Row r uses the matrix row rotated right by r: coef[(k-r) mod 4] * b[k]
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8] ^
                               gf_mul(col_in[31-8*k -: 8], mc_coef(inv, (k - r + 4) % 4));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mix_columns_iter.sv
// +----------------------------------------------------------------------------+
// | mix_columns_iter                                                           |
// | Handshaked iterative MixColumns/InvMixColumns engine, COLS_PER_CYCLE       |
// | columns per clock. Optional final-round bypass via MIXCOL_BYPASS_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  mc_state_e      r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_inv;
  logic           r_live;
  logic           r_out_valid;
  logic [127:0]   r_data;

  logic           w_accept;
  logic           w_inv;
  logic           w_byp;
  logic           w_last;
  logic [CW-1:0]  w_grp;
  logic [31:0]    w_src     [4];
  logic [31:0]    w_mix_in  [COLS_PER_CYCLE];
  logic [31:0]    w_mix_out [COLS_PER_CYCLE];
  logic [127:0]   w_next;

  assign in_ready  = r_live & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;

  // The acceptance cycle already transforms group 0 straight from in_data,
  // which is what gives out_valid exactly NCYC cycles after acceptance.
  assign w_grp  = w_accept ? '0 : r_cnt;
  assign w_inv  = w_accept ? in_inv : r_inv;
  assign w_last = (int'(w_grp) == NCYC - 1);

`ifdef MIXCOL_BYPASS_EN
  logic r_byp;
  assign w_byp = w_accept ? in_bypass : r_byp;
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_src[c] = w_accept ? in_data[127-32*c -: 32] : r_data[127-32*c -: 32];
    end
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_mix_in[j] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      if (c / COLS_PER_CYCLE == int'(w_grp)) begin
        w_mix_in[c % COLS_PER_CYCLE] = w_src[c];
      end
    end
  end

  always_comb begin
    w_next = '0;
    for (int c = 0; c < 4; c++) begin
      if (c / COLS_PER_CYCLE == int'(w_grp)) begin
        w_next[127-32*c -: 32] = w_byp ? w_src[c] : w_mix_out[c % COLS_PER_CYCLE];
      end else begin
        w_next[127-32*c -: 32] = w_src[c];
      end
    end
  end

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix
      mix_column_word u_mix (
        .col_in  (w_mix_in[j]),
        .inv     (w_inv),
        .col_out (w_mix_out[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_inv       <= 1'b0;
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
`ifdef MIXCOL_BYPASS_EN
      r_byp       <= 1'b0;
`endif
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_data <= w_next;
        r_inv  <= in_inv;
`ifdef MIXCOL_BYPASS_EN
        r_byp  <= in_bypass;
`endif
        if (w_last) begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_state     <= ST_BUSY;
          r_out_valid <= 1'b0;
          r_cnt       <= CW'(1);
        end
      end else begin
        case (r_state)
          ST_BUSY: begin
            r_data <= w_next;
            if (w_last) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
            end
          end
          ST_IDLE: ;
          default: begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
// +----------------------------------------------------------------------------+
// | tb_mix_columns_iter                                                        |
// | Self-checking bench: three engines (1, 2, 4 columns/clock) vs a GF model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mix_columns_iter;

  logic         clk;
  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
`ifdef MIXCOL_BYPASS_EN
  logic         in_bypass [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n[g]),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .in_inv    (in_inv[g]),
`ifdef MIXCOL_BYPASS_EN
        .in_bypass (in_bypass[g]),
`endif
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g])
      );
    end
  endgenerate

  // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [7:0]   m [4][4];
    logic [7:0]   b [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                   '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    else     m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                   '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = d[127-32*c-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[r][k], b[k]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state, wait (bounded) for the result, then complete the handshake.
  task automatic run_txn(input int i, input logic [127:0] d, input logic inv,
                         output logic [127:0] got, output int lat);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_inv[i]   = inv;
    step();
    in_valid[i] = 1'b0;
    in_data[i]  = rnd128();
    lat = 1;
    while (!out_valid[i] && lat < 32) begin
      step();
      lat++;
    end
    if (!out_valid[i]) lat = -1;
    got = out_data[i];
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
      in_inv[i] = 1'b0; out_ready[i] = 1'b0;
`ifdef MIXCOL_BYPASS_EN
      in_bypass[i] = 1'b0;
`endif
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || out_data[i] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, required 0/0/0",
                 i, in_ready[i], out_valid[i], out_data[i]);
      end
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: in_ready=%b out_valid=%b, required 1/0",
                 i, in_ready[i], out_valid[i]);
      end
    end
  endtask

  task automatic test_vectors(input int i);
    logic [127:0] din [4];
    logic         inv [4];
    logic [127:0] exp [4];
    logic [127:0] got;
    int           lat;
    din[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6; inv[0] = 1'b0;
    exp[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    din[1] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; inv[1] = 1'b1;
    exp[1] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    din[2] = {4{32'hd4bf5d30}}; inv[2] = 1'b0; exp[2] = {4{32'h046681e5}};
    din[3] = {4{32'h046681e5}}; inv[3] = 1'b1; exp[3] = {4{32'hd4bf5d30}};
    for (int v = 0; v < 4; v++) begin
      run_txn(i, din[v], inv[v], got, lat);
      n_checks++;
      if (lat !== (4 >> i)) begin
        n_fail++;
        $display("FAIL vec_latency[%0d] v%0d: got %0d cycles, required %0d", i, v, lat, 4 >> i);
      end
      n_checks++;
      if (got !== exp[v]) begin
        n_fail++;
        $display("FAIL vec_data[%0d] v%0d: got %h, required %h", i, v, got, exp[v]);
      end
    end
  endtask

  task automatic test_random(input int i);
    logic [127:0] d;
    logic [127:0] got;
    logic         inv;
    int           lat;
    for (int n = 0; n < 8; n++) begin
      d   = rnd128();
      inv = 1'($urandom_range(0, 1));
      run_txn(i, d, inv, got, lat);
      n_checks++;
      if (got !== model(d, inv) || lat !== (4 >> i)) begin
        n_fail++;
        $display("FAIL random[%0d] n%0d inv=%b: got %h lat %0d, required %h lat %0d",
                 i, n, inv, got, lat, model(d, inv), 4 >> i);
      end
    end
  endtask

  task automatic test_back_to_back(input int i);
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] snap;
    logic         inva;
    logic         invb;
    int           n;
    a = rnd128(); b = rnd128();
    inva = 1'($urandom_range(0, 1)); invb = ~inva;
    in_valid[i] = 1'b1; in_data[i] = a; in_inv[i] = inva;
    step();
    in_data[i] = b; in_inv[i] = invb;
    n = 1;
    while (!out_valid[i] && n < 32) begin step(); n++; end
    snap = out_data[i];
    n_checks++;
    if (out_valid[i] !== 1'b1 || snap !== model(a, inva)) begin
      n_fail++;
      $display("FAIL bp_first[%0d]: valid=%b data=%h, required 1 %h", i, out_valid[i], snap, model(a, inva));
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid[i] !== 1'b1 || out_data[i] !== snap || in_ready[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] c%0d: valid=%b ready=%b data=%h, required 1/0 %h",
                 i, k, out_valid[i], in_ready[i], out_data[i], snap);
      end
      step();
    end
    out_ready[i] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready[%0d]: in_ready=%b, required 1", i, in_ready[i]);
    end
    step();
    in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_inv[i] = inva;
    n = 1;
    while (!out_valid[i] && n < 32) begin step(); n++; end
    n_checks++;
    if (out_valid[i] !== 1'b1 || n !== (4 >> i) || out_data[i] !== model(b, invb)) begin
      n_fail++;
      $display("FAIL b2b_second[%0d]: valid=%b lat=%0d data=%h, required 1 %0d %h",
               i, out_valid[i], n, out_data[i], 4 >> i, model(b, invb));
    end
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
  endtask

  task automatic test_mode_sampling(input int i);
    logic [127:0] d;
    logic         inv;
    int           n;
    d = rnd128(); inv = 1'($urandom_range(0, 1));
    in_valid[i] = 1'b1; in_data[i] = d; in_inv[i] = inv;
    step();
    in_valid[i] = 1'b0;
    in_inv[i]   = ~inv;
    n = 1;
    while (!out_valid[i] && n < 32) begin
      step();
      in_inv[i] = ~in_inv[i];
      n++;
    end
    in_inv[i] = ~in_inv[i];
    #1;
    n_checks++;
    if (out_valid[i] !== 1'b1 || out_data[i] !== model(d, inv)) begin
      n_fail++;
      $display("FAIL mode_sample[%0d] inv=%b: valid=%b data=%h, required 1 %h",
               i, inv, out_valid[i], out_data[i], model(d, inv));
    end
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
  endtask

  task automatic test_reset_mid(input int i);
    logic [127:0] d;
    logic [127:0] got;
    int           lat;
    d = rnd128();
    in_valid[i] = 1'b1; in_data[i] = rnd128(); in_inv[i] = 1'b0;
    step();
    in_valid[i] = 1'b0;
    rst_n[i] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[i] !== 1'b0 || out_data[i] !== 128'h0 || in_ready[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid[%0d]: valid=%b ready=%b data=%h, required 0/0/0",
               i, out_valid[i], in_ready[i], out_data[i]);
    end
    step();
    rst_n[i] = 1'b1;
    step();
    step();
    n_checks++;
    if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release[%0d]: ready=%b valid=%b, required 1/0", i, in_ready[i], out_valid[i]);
    end
    run_txn(i, d, 1'b1, got, lat);
    n_checks++;
    if (got !== model(d, 1'b1) || lat !== (4 >> i)) begin
      n_fail++;
      $display("FAIL reset_mid_fresh[%0d]: got %h lat %0d, required %h lat %0d",
               i, got, lat, model(d, 1'b1), 4 >> i);
    end
  endtask

`ifdef MIXCOL_BYPASS_EN
  task automatic test_bypass(input int i);
    logic [127:0] d;
    logic [127:0] got;
    int           lat;
    d = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_bypass[i] = 1'b1;
    run_txn(i, d, 1'($urandom_range(0, 1)), got, lat);
    in_bypass[i] = 1'b0;
    n_checks++;
    if (got !== d || lat !== (4 >> i)) begin
      n_fail++;
      $display("FAIL bypass[%0d]: got %h lat %0d, required %h lat %0d", i, got, lat, d, 4 >> i);
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int i = 0; i < 3; i++) begin
      test_vectors(i);
      test_random(i);
      test_back_to_back(i);
      test_mode_sampling(i);
      test_reset_mid(i);
`ifdef MIXCOL_BYPASS_EN
      test_bypass(i);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
